// File: rtl/psc_trigger_receiver_pkg.sv
// rtl/psc_trigger_receiver_pkg.sv - frame constants and lock state shared by PSC trigger link ends
package psc_trigger_pkg;

    localparam int FRAME_WIDTH = 100;

    // Transmitted MSB first; the transmitter sends exactly these frames back to back.
    localparam logic [FRAME_WIDTH-1:0] IDLE_FRAME    = 100'hC0C0C0C0C0C0C0C0C0C0C0C0C;
    localparam logic [FRAME_WIDTH-1:0] TRIGGER_FRAME = 100'hFF00FF00FF00FF00FF00FF00F;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/psc_trigger_receiver_if.sv
// rtl/psc_trigger_receiver_if.sv - serial input, counter clear and decoded status of the trigger receiver
interface psc_trigger_receiver_if #(
    parameter int CNT_W = 16
);
    logic             psc_input;
    logic             clear_counts;
    logic             trigger_out;
    logic             locked;
    logic             frame_valid;
    logic             frame_error;
    logic [CNT_W-1:0] trigger_count;
    logic [CNT_W-1:0] error_count;

    modport slave (
        input  psc_input, clear_counts,
        output trigger_out, locked, frame_valid, frame_error, trigger_count, error_count
    );

    modport master (
        output psc_input, clear_counts,
        input  trigger_out, locked, frame_valid, frame_error, trigger_count, error_count
    );
endinterface

// File: rtl/psc_trigger_receiver_bit_sampler.sv
// rtl/psc_trigger_receiver_bit_sampler.sv - synchronizer and edge-realigned mid-bit sample strobe
module psc_bit_sampler #(
    parameter int CLKS_PER_BIT = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic serial_in,
    output logic bit_out,
    output logic bit_strobe
);
    localparam int             PW        = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0]  PHASE_END = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0]  PHASE_MID = PW'(CLKS_PER_BIT / 2);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_dly;
    logic [PW-1:0] r_phase;
    logic          w_edge;

    assign w_edge = r_sync2 ^ r_dly;

    // Every line transition re-centres the sample point; long runs rely on the wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
            r_phase <= '0;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
            if (w_edge || r_phase == PHASE_END) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    assign bit_out    = r_sync2;
    assign bit_strobe = (r_phase == PHASE_MID);

endmodule

// File: rtl/psc_trigger_receiver.sv
// rtl/psc_trigger_receiver.sv - frame alignment, idle/trigger decode and saturating link status counters
module psc_trigger_receiver
    import psc_trigger_pkg::*;
#(
    parameter int                   CLKS_PER_BIT    = 5,
    parameter int                   WIDTH           = FRAME_WIDTH,
    parameter logic [WIDTH-1:0]     IDLE_PATTERN    = IDLE_FRAME,
    parameter logic [WIDTH-1:0]     TRIGGER_PATTERN = TRIGGER_FRAME,
    parameter int                   LOSS_FRAMES     = 3,
    parameter int                   CNT_W           = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    psc_trigger_receiver_if.slave   bus
);
    localparam int               BCW     = $clog2(WIDTH);
    localparam int               BFW     = $clog2(LOSS_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_window;
    logic [BCW-1:0]   r_bit_cnt;
    logic [BCW-1:0]   w_bit_cnt;
    logic [BFW-1:0]   r_bad;
    logic [BFW-1:0]   w_bad;
    logic             w_bit;
    logic             w_strobe;
    logic             w_is_idle;
    logic             w_is_trig;
    logic             w_valid;
    logic             w_trig;
    logic             w_err;
    logic             r_trigger_out;
    logic             r_frame_valid;
    logic             r_frame_error;
    logic [CNT_W-1:0] r_trigger_count;
    logic [CNT_W-1:0] r_error_count;

    psc_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (bus.psc_input),
        .bit_out    (w_bit),
        .bit_strobe (w_strobe)
    );

    // Decisions look at the window including the bit being sampled right now.
    assign w_window  = {r_shift[WIDTH-2:0], w_bit};
    assign w_is_idle = (w_window == IDLE_PATTERN);
    assign w_is_trig = (w_window == TRIGGER_PATTERN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_bit_cnt    = r_bit_cnt;
        w_bad        = r_bad;
        w_valid      = 1'b0;
        w_trig       = 1'b0;
        w_err        = 1'b0;
        if (w_strobe) begin
            case (r_state)
                HUNT: begin
                    if (w_is_idle) begin
                        w_next_state = LOCKED;
                        w_bit_cnt    = '0;
                        w_bad        = '0;
                    end
                end
                LOCKED: begin
                    if (r_bit_cnt == BCW'(WIDTH - 1)) begin
                        w_bit_cnt = '0;
                        if (w_is_idle || w_is_trig) begin
                            w_valid = 1'b1;
                            w_trig  = w_is_trig;
                            w_bad   = '0;
                        end else begin
                            w_err = 1'b1;
                            w_bad = r_bad + 1'b1;
                            if (w_bad == BFW'(LOSS_FRAMES)) begin
                                w_next_state = HUNT;
                            end
                        end
                    end else begin
                        w_bit_cnt = r_bit_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift         <= '0;
            r_bit_cnt       <= '0;
            r_bad           <= '0;
            r_trigger_out   <= 1'b0;
            r_frame_valid   <= 1'b0;
            r_frame_error   <= 1'b0;
            r_trigger_count <= '0;
            r_error_count   <= '0;
        end else begin
            if (w_strobe) begin
                r_shift <= w_window;
            end
            r_bit_cnt     <= w_bit_cnt;
            r_bad         <= w_bad;
            r_trigger_out <= w_trig;
            r_frame_valid <= w_valid;
            r_frame_error <= w_err;
            // A clear landing on the same edge as an increment still leaves zero.
            if (bus.clear_counts) begin
                r_trigger_count <= '0;
                r_error_count   <= '0;
            end else begin
                if (w_trig && r_trigger_count != CNT_MAX) begin
                    r_trigger_count <= r_trigger_count + 1'b1;
                end
                if (w_err && r_error_count != CNT_MAX) begin
                    r_error_count <= r_error_count + 1'b1;
                end
            end
        end
    end

    assign bus.trigger_out   = r_trigger_out;
    assign bus.frame_valid   = r_frame_valid;
    assign bus.frame_error   = r_frame_error;
    assign bus.locked        = (r_state == LOCKED);
    assign bus.trigger_count = r_trigger_count;
    assign bus.error_count   = r_error_count;

endmodule

// File: tb/tb_psc_trigger_receiver.sv
// tb/tb_psc_trigger_receiver.sv - scoreboard bench for the PSC trigger receiver
module tb_psc_trigger_receiver;
    import psc_trigger_pkg::*;

    localparam int CPB   = 5;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int LOSS  = 3;
    localparam logic [99:0] ZERO_FRAME = '0;

    typedef struct {
        int         cyc;
        logic [3:0] flags;
        int         tcnt;
        int         ecnt;
    } evt_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    logic prev_locked = 1'b0;
    evt_t q[$];
    evt_t mon_e;
    logic [3:0] mon_flags;

    bit m_locked;
    int m_bad;
    int m_tcnt;
    int m_ecnt;

    psc_trigger_receiver_if #(.CNT_W(CNT_W)) bus ();

    psc_trigger_receiver #(
        .CLKS_PER_BIT (CPB),
        .LOSS_FRAMES  (LOSS),
        .CNT_W        (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    always @(negedge clk) begin
        mon_flags = {bus.frame_valid, bus.trigger_out, bus.frame_error, bus.locked};
        if (mon_en && (bus.frame_valid || bus.trigger_out || bus.frame_error || bus.locked != prev_locked)) begin
            if (q.size() == 0) begin
                check("spurious_event", 32'(mon_flags), 32'hFFFF_FFFF);
            end else begin
                mon_e = q.pop_front();
                check("event_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("event_flags", 32'(mon_flags), 32'(mon_e.flags));
                check("trigger_count", 32'(bus.trigger_count), 32'(mon_e.tcnt));
                check("error_count", 32'(bus.error_count), 32'(mon_e.ecnt));
            end
        end
        prev_locked <= bus.locked;
    end

    // Drives bits [first..last] of a frame; full frames also update the model and queue the outcome.
    task automatic send_frame(input logic [99:0] pat, input int first, input int last,
                              input bit jit, input bit clr);
        int         dur;
        int         k_last;
        bit         has_evt;
        logic [3:0] f;
        k_last = cyc;
        for (int i = first; i <= last; i++) begin
            dur = CPB;
            if (jit && i < 99) begin
                if (pat[99-i] != pat[98-i]) dur = CPB - 1 + int'($urandom_range(0, 2));
            end
            bus.psc_input = pat[99-i];
            k_last = cyc;
            repeat (dur) @(negedge clk);
        end
        if (first == 0 && last == 99) begin
            has_evt = 1'b0;
            f = 4'b0000;
            if (!m_locked) begin
                if (pat == IDLE_FRAME) begin
                    m_locked = 1'b1;
                    m_bad    = 0;
                    has_evt  = 1'b1;
                    f        = 4'b0001;
                end
            end else if (pat == IDLE_FRAME) begin
                m_bad = 0; has_evt = 1'b1; f = 4'b1001;
            end else if (pat == TRIGGER_FRAME) begin
                m_bad = 0; m_tcnt = sat_inc(m_tcnt); has_evt = 1'b1; f = 4'b1101;
            end else begin
                m_ecnt = sat_inc(m_ecnt);
                m_bad++;
                if (m_bad >= LOSS) m_locked = 1'b0;
                has_evt = 1'b1;
                f = {3'b001, m_locked};
            end
            if (clr) begin
                m_tcnt = 0;
                m_ecnt = 0;
            end
            if (has_evt) q.push_back('{k_last + 6, f, m_tcnt, m_ecnt});
        end
        if (clr) begin
            bus.clear_counts = 1'b1;
            fork
                begin
                    @(posedge clk);
                    @(negedge clk);
                    bus.clear_counts = 1'b0;
                end
            join_none
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_locked = 1'b0;
        m_bad    = 0;
        m_tcnt   = 0;
        m_ecnt   = 0;
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        reset = 1'b0;
        bus.psc_input = 1'b0;
        bus.clear_counts = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_locked"}, 32'(bus.locked), 32'd0);
        check({pfx, "_trigger_out"}, 32'(bus.trigger_out), 32'd0);
        check({pfx, "_frame_valid"}, 32'(bus.frame_valid), 32'd0);
        check({pfx, "_frame_error"}, 32'(bus.frame_error), 32'd0);
        check({pfx, "_trigger_count"}, 32'(bus.trigger_count), 32'd0);
        check({pfx, "_error_count"}, 32'(bus.error_count), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        bus.psc_input = 1'b0;
        bus.clear_counts = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;

        // Aligned idle stream, then a trigger frame
        repeat (5) send_frame(IDLE_FRAME, 0, 99, 1'b0, 1'b0);
        send_frame(TRIGGER_FRAME, 0, 99, 1'b0, 1'b0);
        send_frame(IDLE_FRAME, 0, 99, 1'b0, 1'b0);

        // Start mid-frame at bit 37
        apply_reset();
        send_frame(IDLE_FRAME, 37, 99, 1'b0, 1'b0);
        repeat (2) send_frame(IDLE_FRAME, 0, 99, 1'b0, 1'b0);

        // Two bad frames keep lock, three drop it, idle relocks
        repeat (2) send_frame(ZERO_FRAME, 0, 99, 1'b0, 1'b0);
        send_frame(IDLE_FRAME, 0, 99, 1'b0, 1'b0);
        repeat (3) send_frame(ZERO_FRAME, 0, 99, 1'b0, 1'b0);
        repeat (2) send_frame(IDLE_FRAME, 0, 99, 1'b0, 1'b0);

        // Jittered transitions
        apply_reset();
        send_frame(IDLE_FRAME, 0, 99, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_frame((i % 2 == 0) ? TRIGGER_FRAME : IDLE_FRAME, 0, 99, 1'b1, 1'b0);
        end

        // Saturation, then clear coinciding with a trigger pulse
        apply_reset();
        send_frame(IDLE_FRAME, 0, 99, 1'b0, 1'b0);
        repeat (CMAX + 2) send_frame(TRIGGER_FRAME, 0, 99, 1'b0, 1'b0);
        send_frame(TRIGGER_FRAME, 0, 99, 1'b0, 1'b1);
        send_frame(IDLE_FRAME, 0, 99, 1'b0, 1'b0);
        send_frame(TRIGGER_FRAME, 0, 99, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a trigger frame
        send_frame(TRIGGER_FRAME, 0, 49, 1'b0, 1'b0);
        check("pre_reset_locked", 32'(bus.locked), 32'(m_locked));
        check("pre_reset_trigger_count", 32'(bus.trigger_count), 32'(m_tcnt));
        #2;
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        bus.psc_input = 1'b0;
        @(negedge clk);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;
        repeat (2) send_frame(IDLE_FRAME, 0, 99, 1'b0, 1'b0);

        repeat (20) @(negedge clk);
        check("pending_events", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psc_trigger_receiver.md
Name: psc_trigger_receiver

Overview:
Receive side of the PSC trigger serial link. It recovers bits from the serial line, which carries back-to-back 100-bit frames sent MSB first at 10 MHz: an idle frame (100'hC0C0C0C0C0C0C0C0C0C0C0C0C) or a trigger frame (100'hFF00FF00FF00FF00FF00FF00F). It aligns to frame boundaries and decodes each frame into a one-cycle trigger pulse plus link-health status. It sits at the power-supply-controller end of the link and runs on the 50 MHz board clock, oversampling the line 5x.

Parameters:
CLKS_PER_BIT, 5, clk cycles per serial bit (50 MHz / 10 MHz); minimum 3
WIDTH, 100, frame length in bits
IDLE_PATTERN, 100'hC0C0C0C0C0C0C0C0C0C0C0C0C, idle frame, MSB transmitted first
TRIGGER_PATTERN, 100'hFF00FF00FF00FF00FF00FF00F, trigger frame, MSB transmitted first
LOSS_FRAMES, 3, consecutive bad frames that drop lock
CNT_W, 16, width of the status counters

Ports:
clk  input  1  50 MHz system clock; all logic on its rising edge
reset  input  1  asynchronous, active-low reset
psc_input  input  1  serial line, asynchronous to clk
clear_counts  input  1  synchronous clear of both counters
trigger_out  output  1  one-cycle pulse per decoded trigger frame
locked  output  1  high while frame-aligned
frame_valid  output  1  one-cycle pulse per frame matching idle or trigger
frame_error  output  1  one-cycle pulse per frame matching neither pattern while locked
trigger_count  output  CNT_W  decoded trigger frames, saturating
error_count  output  CNT_W  bad frames while locked, saturating

Behaviour:
- Reset (asserted, asynchronous):
  - All outputs are 0.
  - Shift register, phase counter and bit counter are 0; bad-frame counter is 0.
  - Both synchronizer flops are 0.
  - State is HUNT.
- Reset asserted mid-frame aborts the frame with no pulse. After release, the block re-hunts from scratch.
- Bit recovery:
  - psc_input passes through a 2-flop synchronizer, then one more delay flop for edge detection.
  - Any transition on the synchronized line loads the phase counter with 0. Otherwise the phase counter counts 0..CLKS_PER_BIT-1 and wraps.
  - A sample strobe fires when phase == CLKS_PER_BIT/2 (integer division; 2 by default).
  - On each strobe, shift_reg <= {shift_reg[WIDTH-2:0], bit}, so the first-sent bit ends up in the MSB.
  - During a long run of equal bits, the free-running phase wrap keeps sampling at the nominal bit rate.
- State HUNT:
  - locked = 0.
  - On each strobe, compare the post-shift window with IDLE_PATTERN. Exact 100-bit equality is required; any other alignment of the idle stream mismatches.
  - On a match: go to LOCKED, set bit_cnt to 0, clear the bad-frame counter, and raise locked the next cycle.
  - A TRIGGER_PATTERN window never establishes lock.
- State LOCKED:
  - locked = 1.
  - bit_cnt increments on each strobe, 0..WIDTH-1, and wraps.
  - The strobe on which bit_cnt == WIDTH-1 is the frame end; bit_cnt returns to 0 there. At frame end, the post-shift window is evaluated:
    - IDLE_PATTERN: frame_valid pulses; bad-frame counter := 0.
    - TRIGGER_PATTERN: frame_valid and trigger_out pulse; trigger_count +1; bad-frame counter := 0.
    - Anything else: frame_error pulses; error_count +1; bad-frame counter +1.
  - When the bad-frame counter reaches LOSS_FRAMES, the state returns to HUNT in the same update.
- Latency:
  - All pulses are registered and high for exactly the one cycle after the frame-end strobe cycle.
  - trigger_out is therefore 1 clk after the last bit is sampled.
  - Counter updates are visible in the same cycle as the pulse.
- Counters:
  - Both saturate at 2^CNT_W-1.
  - clear_counts zeroes both on the next edge. If it coincides with an increment, clear wins.
  - clear_counts does not affect state or lock.
- Trigger frames arrive only when aligned. No triggers are reported while in HUNT.

Decomposition:
- Package psc_trigger_pkg holds:
  - the WIDTH constant;
  - the IDLE_PATTERN and TRIGGER_PATTERN constants, so they are shared with the transmitter;
  - the HUNT/LOCKED state encoding.
- One sub-module, psc_bit_sampler:
  - contains the synchronizer, edge detector and phase counter;
  - ports: clk, reset, serial_in; outputs bit_out, bit_strobe.
- The top level holds the shift register, state machine, frame comparison and counters.

Test Plan:
- Idle stream, 5 frames, aligned MSB first at 5 clk/bit → locked rises after the 100th bit of the first frame; frame_valid pulses once per 500 clk; trigger_out never pulses.
- Locked, then one trigger frame inserted → trigger_out high exactly 1 clk, 1 clk after its final bit is sampled; trigger_count = 1.
- Start transmission mid-frame at bit 37 → no lock on the partial frame; locked rises at the end of the first complete idle frame; zero frame_error.
- Locked, then 2 frames of all-zeros followed by an idle frame → 2 frame_error pulses, error_count = 2, locked stays 1. Repeat with 3 bad frames → locked drops after the 3rd, then relocks on the next idle frame.
- Transmitter bit period jittered ±1 clk on transitions, with the 8-bit runs of FF00 → all frames decoded; error_count = 0.
- trigger_count preset to 16'hFFFF by repeated triggers → stays 16'hFFFF. clear_counts on the same cycle as a trigger pulse → count = 0. reset asserted mid-frame → all outputs 0 immediately, asynchronously.
